// File: rtl/regfile_vector_sb.sv
// Multi-lane register file with per-lane write masks, scalar broadcast and a pending-write scoreboard.
// Data is written on the falling edge; the scoreboard advances on the rising edge.
module regfile_vector_sb #(
    parameter int                DATA_W    = 16,
    parameter int                LANES     = 4,
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] RESET_VAL = 16'h0001,
    parameter bit                ZERO_REG  = 1'b0,
    localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [LANES*DATA_W-1:0] wd,
    input  logic [LANES-1:0]        wmask,
    input  logic                    bcast,
    input  logic [ADDR_W-1:0]       ra1,
    input  logic [ADDR_W-1:0]       ra2,
    input  logic [ADDR_W-1:0]       ra3,
    output logic [LANES*DATA_W-1:0] rd1,
    output logic [LANES*DATA_W-1:0] rd2,
    output logic [LANES*DATA_W-1:0] rd3,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic                    busy1,
    output logic                    busy2,
    output logic                    busy3,
    output logic [CNT_W-1:0]        pend_cnt
);

    logic [LANES*DATA_W-1:0] rf_q [DEPTH];
    logic [LANES*DATA_W-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0]        pend_q, pend_d;
    logic [CNT_W-1:0]        pend_cnt_q, pend_cnt_d;
    logic                    set_hit, clr_hit;

    // An address is live when it exists in the file and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(DEPTH)) && !(ZERO_REG && (a == '0));
    endfunction

    always_comb begin
        rf_d = rf_q;
        if (we && addr_ok(wa)) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    rf_d[wa][i*DATA_W +: DATA_W] = bcast ? wd[DATA_W-1:0]
                                                         : wd[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                rf_q[r] <= (ZERO_REG && (r == 0)) ? '0 : {LANES{RESET_VAL}};
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        rd3 = '0;
        if (addr_ok(ra1)) rd1 = rf_q[ra1];
        if (addr_ok(ra2)) rd2 = rf_q[ra2];
        if (addr_ok(ra3)) rd3 = rf_q[ra3];
    end

    // A same-cycle issue to the write address is a new producer, so the set beats the clear.
    always_comb begin
        pend_d     = pend_q;
        pend_cnt_d = pend_cnt_q;
        set_hit    = iss_valid && addr_ok(iss_addr);
        clr_hit    = we && addr_ok(wa);
        if (clr_hit && pend_q[wa] && !(set_hit && (iss_addr == wa))) begin
            pend_d[wa] = 1'b0;
            pend_cnt_d = pend_cnt_d - 1'b1;
        end
        if (set_hit && !pend_q[iss_addr]) begin
            pend_d[iss_addr] = 1'b1;
            pend_cnt_d       = pend_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    // A writeback in flight this cycle forwards through the file, so it does not stall.
    always_comb begin
        busy1 = addr_ok(ra1) && pend_q[ra1] && !(we && (wa == ra1));
        busy2 = addr_ok(ra2) && pend_q[ra2] && !(we && (wa == ra2));
        busy3 = addr_ok(ra3) && pend_q[ra3] && !(we && (wa == ra3));
    end

endmodule

// File: tb/tb_regfile_vector_sb.sv
// Directed bench for regfile_vector_sb: a normal file (A) and a zero-register file (B) share stimulus;
// expectations are queued by the stimulus and compared by a separate monitor.
module tb_regfile_vector_sb;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 5;
    localparam int W      = LANES * DATA_W;

    localparam logic [63:0] RST4 = 64'h0001_0001_0001_0001;

    localparam int S_RD1_A = 0, S_RD2_A = 1, S_RD3_A = 2, S_B1_A = 3, S_B2_A = 4, S_B3_A = 5, S_CNT_A = 6;
    localparam int S_RD1_B = 10, S_RD2_B = 11, S_B1_B = 13, S_CNT_B = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              we = 1'b0, bcast = 1'b0, iss_valid = 1'b0;
    logic [ADDR_W-1:0] wa = '0, ra1 = '0, ra2 = '0, ra3 = '0, iss_addr = '0;
    logic [W-1:0]      wd = '0;
    logic [LANES-1:0]  wmask = '0;

    logic [W-1:0]      rd1_a, rd2_a, rd3_a, rd1_b, rd2_b, rd3_b;
    logic              busy1_a, busy2_a, busy3_a, busy1_b, busy2_b, busy3_b;
    logic [CNT_W-1:0]  cnt_a, cnt_b;

    always #5 clk = ~clk;

    regfile_vector_sb #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ZERO_REG(1'b0)) dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wmask(wmask), .bcast(bcast),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .rd1(rd1_a), .rd2(rd2_a), .rd3(rd3_a),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .busy1(busy1_a), .busy2(busy2_a), .busy3(busy3_a), .pend_cnt(cnt_a)
    );

    regfile_vector_sb #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wmask(wmask), .bcast(bcast),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .rd1(rd1_b), .rd2(rd2_b), .rd3(rd3_b),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .busy1(busy1_b), .busy2(busy2_b), .busy3(busy3_b), .pend_cnt(cnt_b)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t exp_q[$];
    event check_ev;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            S_RD1_A: return rd1_a;
            S_RD2_A: return rd2_a;
            S_RD3_A: return rd3_a;
            S_B1_A:  return 64'(busy1_a);
            S_B2_A:  return 64'(busy2_a);
            S_B3_A:  return 64'(busy3_a);
            S_CNT_A: return 64'(cnt_a);
            S_RD1_B: return rd1_b;
            S_RD2_B: return rd2_b;
            S_B1_B:  return 64'(busy1_b);
            S_CNT_B: return 64'(cnt_b);
            default: return '1;
        endcase
    endfunction

    // Monitor: drains every queued expectation when the stimulus marks a sample point.
    initial begin
        exp_t        e;
        logic [63:0] act;
        forever begin
            @(check_ev);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = observe(e.sel);
                n_chk++;
                if (act === e.exp) n_pass++;
                else $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic push_exp(input string n, input int sel, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic check_now();
        -> check_ev;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) #0;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL monitor_drain: %0d left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle();
        we        = 1'b0;
        iss_valid = 1'b0;
        wmask     = '0;
        bcast     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    initial begin
        ra1 = 4'd0; ra2 = 4'd3; ra3 = 4'd15;
        #23;
        rst = 1'b0;
        #1;
        push_exp("rst_rd1_a", S_RD1_A, RST4);
        push_exp("rst_rd2_a", S_RD2_A, RST4);
        push_exp("rst_rd3_a", S_RD3_A, RST4);
        push_exp("rst_rd1_b_zero", S_RD1_B, 64'h0);
        push_exp("rst_rd2_b", S_RD2_B, RST4);
        push_exp("rst_busy1", S_B1_A, 64'h0);
        push_exp("rst_busy2", S_B2_A, 64'h0);
        push_exp("rst_busy3", S_B3_A, 64'h0);
        push_exp("rst_cnt_a", S_CNT_A, 64'h0);
        push_exp("rst_cnt_b", S_CNT_B, 64'h0);
        check_now();

        // Write and issue r3, then reset in the middle of a cycle.
        step();
        we = 1'b1; wa = 4'd3; wmask = 4'hF; wd = 64'h1234_5678_9ABC_DEF0;
        iss_valid = 1'b1; iss_addr = 4'd3;
        half();
        push_exp("r3_write", S_RD2_A, 64'h1234_5678_9ABC_DEF0);
        check_now();
        step();
        idle();
        push_exp("r3_cnt", S_CNT_A, 64'd1);
        push_exp("r3_busy", S_B2_A, 64'd1);
        check_now();
        #2 rst = 1'b1;
        #1;
        push_exp("midrst_rd2", S_RD2_A, RST4);
        push_exp("midrst_cnt", S_CNT_A, 64'd0);
        push_exp("midrst_busy2", S_B2_A, 64'd0);
        check_now();
        #3 rst = 1'b0;

        // Masked writes, broadcast, and empty mask.
        step();
        ra1 = 4'd5; we = 1'b1; wa = 4'd5; wmask = 4'b0101; bcast = 1'b0;
        wd = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        half();
        push_exp("mask_write", S_RD1_A, 64'h0001_CCCC_0001_AAAA);
        check_now();
        step();
        bcast = 1'b1;
        push_exp("bcast_first_half", S_RD1_A, 64'h0001_CCCC_0001_AAAA);
        check_now();
        half();
        push_exp("bcast_write", S_RD1_A, 64'h0001_AAAA_0001_AAAA);
        check_now();
        step();
        wmask = 4'b0000; bcast = 1'b0; wd = '1;
        half();
        push_exp("mask_zero_hold", S_RD1_A, 64'h0001_AAAA_0001_AAAA);
        check_now();

        // Issue r7, write it back four cycles later.
        step();
        idle();
        ra1 = 4'd7; iss_valid = 1'b1; iss_addr = 4'd7;
        push_exp("iss7_c0_busy", S_B1_A, 64'd0);
        push_exp("iss7_c0_cnt", S_CNT_A, 64'd0);
        check_now();
        step();
        iss_valid = 1'b0;
        push_exp("iss7_c1_busy", S_B1_A, 64'd1);
        push_exp("iss7_c1_cnt", S_CNT_A, 64'd1);
        check_now();
        step();
        step();
        step();
        we = 1'b1; wa = 4'd7; wmask = 4'b0000;
        push_exp("wb7_c4_busy", S_B1_A, 64'd0);
        push_exp("wb7_c4_cnt", S_CNT_A, 64'd1);
        check_now();
        step();
        idle();
        push_exp("wb7_c5_cnt", S_CNT_A, 64'd0);
        push_exp("wb7_c5_busy", S_B1_A, 64'd0);
        check_now();

        // Same-cycle issue and writeback.
        ra1 = 4'd2; ra2 = 4'd4;
        iss_valid = 1'b1; iss_addr = 4'd2;
        step();
        we = 1'b1; wa = 4'd2; wmask = 4'b0000;
        push_exp("setclr_same_pre_cnt", S_CNT_A, 64'd1);
        check_now();
        step();
        idle();
        push_exp("setclr_same_cnt", S_CNT_A, 64'd1);
        push_exp("setclr_same_busy", S_B1_A, 64'd1);
        check_now();
        iss_valid = 1'b1; iss_addr = 4'd4; we = 1'b1; wa = 4'd2;
        step();
        idle();
        push_exp("setclr_diff_cnt", S_CNT_A, 64'd1);
        push_exp("setclr_diff_busy2", S_B1_A, 64'd0);
        push_exp("setclr_diff_busy4", S_B2_A, 64'd1);
        check_now();
        we = 1'b1; wa = 4'd4;
        step();
        idle();
        push_exp("clr4_cnt", S_CNT_A, 64'd0);
        check_now();

        // Fill every pending bit, then drain and clear a non-pending register.
        for (int i = 0; i < DEPTH; i++) begin
            step();
            iss_valid = 1'b1;
            iss_addr  = ADDR_W'(i);
        end
        step();
        iss_addr = 4'd0;
        push_exp("full_cnt_a", S_CNT_A, 64'd16);
        push_exp("full_cnt_b", S_CNT_B, 64'd15);
        check_now();
        step();
        iss_valid = 1'b0;
        push_exp("reissue_cnt_a", S_CNT_A, 64'd16);
        push_exp("reissue_cnt_b", S_CNT_B, 64'd15);
        check_now();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            we = 1'b1; wa = ADDR_W'(i); wmask = 4'b0000;
        end
        step();
        wa = 4'd9;
        push_exp("drain_cnt_a", S_CNT_A, 64'd0);
        push_exp("drain_cnt_b", S_CNT_B, 64'd0);
        check_now();
        step();
        idle();
        push_exp("underflow_cnt_a", S_CNT_A, 64'd0);
        push_exp("underflow_cnt_b", S_CNT_B, 64'd0);
        check_now();

        // Zero register: write and issue r0 on both files.
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        step();
        ra1 = 4'd0; we = 1'b1; wa = 4'd0; wmask = 4'hF; wd = '1;
        iss_valid = 1'b1; iss_addr = 4'd0;
        half();
        push_exp("zero_rd_b", S_RD1_B, 64'h0);
        push_exp("r0_rd_a", S_RD1_A, 64'hFFFF_FFFF_FFFF_FFFF);
        check_now();
        step();
        idle();
        push_exp("zero_cnt_b", S_CNT_B, 64'd0);
        push_exp("zero_busy_b", S_B1_B, 64'd0);
        push_exp("r0_cnt_a", S_CNT_A, 64'd1);
        push_exp("r0_busy_a", S_B1_A, 64'd1);
        check_now();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
